// File: rtl/gate_response_checker_if.sv
// Sample/result bundle between a gate-test sequencer (master) and the response checker (slave).
// The master drives the start pulse, truth table and samples; the slave returns run status and results.
interface gate_response_checker_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic [3:0]       truth_table;
   logic             s_valid;
   logic             s_a;
   logic             s_b;
   logic             s_y;
   logic             busy;
   logic             done;
   logic             pass;
   logic [3:0]       covered;
   logic [ERR_W-1:0] err_count;
   logic             first_fail_valid;
   logic [2:0]       first_fail_vec;
   logic             timeout;

   modport master (
      output start, truth_table, s_valid, s_a, s_b, s_y,
      input  busy, done, pass, covered, err_count, first_fail_valid, first_fail_vec, timeout
   );

   modport slave (
      input  start, truth_table, s_valid, s_a, s_b, s_y,
      output busy, done, pass, covered, err_count, first_fail_valid, first_fail_vec, timeout
   );
endinterface

// File: rtl/gate_response_checker.sv
// Checks (a,b,y) samples from a 2-input gate against a truth table latched at start,
// tracking coverage of all four input combinations, mismatches and a RUN-cycle timeout.
module gate_response_checker #(
   parameter int ERR_W   = 8,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   gate_response_checker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

   state_t           state_reg, state_next;
   logic [3:0]       table_reg;
   logic [3:0]       covered_reg;
   logic [3:0]       covered_next;
   logic [3:0]       hit;
   logic [ERR_W-1:0] err_reg;
   logic [TO_W-1:0]  timer_reg;
   logic             ffv_reg;
   logic [2:0]       ffvec_reg;
   logic             timeout_reg;
   logic             timeout_next;
   logic             clear;
   logic             in_run;
   logic             mismatch;
   logic             done_w;
   logic [1:0]       idx;

   assign idx = {bus.s_a, bus.s_b};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_hit
         assign hit[gi] = bus.s_valid && (idx == 2'(gi));
      end
   endgenerate

   // Exit decisions look at coverage including this cycle's sample.
   assign covered_next = covered_reg | hit;
   assign mismatch     = bus.s_valid && (bus.s_y != table_reg[idx]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clear        = 1'b0;
      in_run       = 1'b0;
      timeout_next = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (bus.start) begin
               clear      = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            in_run = 1'b1;
            // Full coverage takes priority over a timeout on the same cycle.
            if (covered_next == 4'hF) begin
               state_next = DONE;
            end else if (timer_reg == TIMER_LAST) begin
               state_next   = DONE;
               timeout_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         table_reg   <= '0;
         covered_reg <= '0;
         err_reg     <= '0;
         timer_reg   <= '0;
         ffv_reg     <= 1'b0;
         ffvec_reg   <= '0;
         timeout_reg <= 1'b0;
      end else if (clear) begin
         table_reg   <= bus.truth_table;
         covered_reg <= '0;
         err_reg     <= '0;
         timer_reg   <= '0;
         ffv_reg     <= 1'b0;
         ffvec_reg   <= '0;
         timeout_reg <= 1'b0;
      end else if (in_run) begin
         timer_reg   <= timer_reg + 1'b1;
         covered_reg <= covered_next;
         timeout_reg <= timeout_next;
         if (mismatch) begin
            if (err_reg != '1) begin
               err_reg <= err_reg + 1'b1;
            end
            if (!ffv_reg) begin
               ffv_reg   <= 1'b1;
               ffvec_reg <= {bus.s_a, bus.s_b, bus.s_y};
            end
         end
      end
   end

   assign done_w               = (state_reg == DONE);
   assign bus.busy             = (state_reg == RUN);
   assign bus.done             = done_w;
   assign bus.pass             = done_w && (err_reg == '0) && !timeout_reg;
   assign bus.covered          = covered_reg;
   assign bus.err_count        = err_reg;
   assign bus.first_fail_valid = ffv_reg;
   assign bus.first_fail_vec   = ffvec_reg;
   assign bus.timeout          = timeout_reg;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: table vectors, hand-written corner sequences and
// randomized runs checked against a cycle-by-cycle reference model of the checking rules.
module tb_gate_response_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start = 1'b0;
   logic [3:0] tt    = 4'b0000;
   logic       sv    = 1'b0;
   logic       sa    = 1'b0;
   logic       sb    = 1'b0;
   logic       sy    = 1'b0;

   // d0: default widths, short timeout; d1: 2-bit error counter; d2: TIMEOUT=4.
   gate_response_checker_if #(.ERR_W(8)) if0 ();
   gate_response_checker_if #(.ERR_W(2)) if1 ();
   gate_response_checker_if #(.ERR_W(8)) if2 ();

   assign if0.start = start; assign if0.truth_table = tt; assign if0.s_valid = sv;
   assign if0.s_a = sa;      assign if0.s_b = sb;         assign if0.s_y = sy;
   assign if1.start = start; assign if1.truth_table = tt; assign if1.s_valid = sv;
   assign if1.s_a = sa;      assign if1.s_b = sb;         assign if1.s_y = sy;
   assign if2.start = start; assign if2.truth_table = tt; assign if2.s_valid = sv;
   assign if2.s_a = sa;      assign if2.s_b = sb;         assign if2.s_y = sy;

   gate_response_checker #(.ERR_W(8), .TO_W(16), .TIMEOUT(20))   d0 (.clk(clk), .rst(rst), .bus(if0));
   gate_response_checker #(.ERR_W(2), .TO_W(16), .TIMEOUT(1000)) d1 (.clk(clk), .rst(rst), .bus(if1));
   gate_response_checker #(.ERR_W(8), .TO_W(16), .TIMEOUT(4))    d2 (.clk(clk), .rst(rst), .bus(if2));

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [3:0]      tt;
      logic [2:0]      n;
      logic [4:0][2:0] s;
      logic [3:0]      cov;
      logic [7:0]      err;
      logic            ffv;
      logic [2:0]      ffvec;
      logic            pass;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Result snapshot layout: {covered, err, ffv, ffvec, done, timeout, pass}
   function automatic logic [18:0] mk(input logic [3:0] cov, input logic [7:0] err, input logic ffv,
                                      input logic [2:0] fv, input logic dn, input logic to, input logic ps);
      return {cov, err, ffv, fv, dn, to, ps};
   endfunction

   function automatic logic [18:0] snap0();
      return mk(if0.covered, if0.err_count, if0.first_fail_valid, if0.first_fail_vec, if0.done, if0.timeout, if0.pass);
   endfunction
   function automatic logic [18:0] snap1();
      return mk(if1.covered, {6'b0, if1.err_count}, if1.first_fail_valid, if1.first_fail_vec, if1.done, if1.timeout, if1.pass);
   endfunction
   function automatic logic [18:0] snap2();
      return mk(if2.covered, if2.err_count, if2.first_fail_valid, if2.first_fail_vec, if2.done, if2.timeout, if2.pass);
   endfunction

   task automatic chk_all(input string tag, input logic [18:0] act, input logic [18:0] exp);
      chk({tag, ".covered"},   32'(act[18:15]), 32'(exp[18:15]));
      chk({tag, ".err_count"}, 32'(act[14:7]),  32'(exp[14:7]));
      chk({tag, ".ff_valid"},  32'(act[6]),     32'(exp[6]));
      chk({tag, ".ff_vec"},    32'(act[5:3]),   32'(exp[5:3]));
      chk({tag, ".done"},      32'(act[2]),     32'(exp[2]));
      chk({tag, ".timeout"},   32'(act[1]),     32'(exp[1]));
      chk({tag, ".pass"},      32'(act[0]),     32'(exp[0]));
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [2:0] abc);
      sv = v;
      {sa, sb, sy} = abc;
   endtask

   task automatic pulse_start(input logic [3:0] t);
      tt    = t;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic do_reset();
      sv    = 1'b0;
      start = 1'b0;
      rst   = 1'b1;
      cyc();
      rst   = 1'b0;
   endtask

   task automatic add_vec(input logic [3:0] t, input int n, input logic [2:0] s0, input logic [2:0] s1,
                          input logic [2:0] s2, input logic [2:0] s3, input logic [2:0] s4,
                          input logic [7:0] err, input logic [2:0] ffvec);
      vec_t v;
      v.tt    = t;
      v.n     = 3'(n);
      v.s[0]  = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3; v.s[4] = s4;
      v.cov   = 4'hF;
      v.err   = err;
      v.ffv   = (err != 0);
      v.ffvec = ffvec;
      v.pass  = (err == 0);
      vecs.push_back(v);
   endtask

   // Reference model: walks RUN cycles applying the checking rules directly.
   // Stream element = {valid, a, b, y}; returns result snapshot and the RUN cycle of completion.
   task automatic model(input logic [3:0] q[$], input logic [3:0] t, input int tmo, input int emax,
                        output logic [18:0] res, output int dc);
      logic [3:0] cov = 0;
      int         err = 0;
      logic       ffv = 0;
      logic [2:0] ffvec = 0;
      logic       to = 0;
      dc = 0;
      for (int c = 1; c <= tmo; c++) begin
         logic [3:0] s;
         int         k;
         s = (c <= q.size()) ? q[c-1] : 4'b0000;
         if (s[3]) begin
            k = {30'b0, s[2:1]};
            cov[k] = 1'b1;
            if (s[0] != t[k]) begin
               if (err < emax) err++;
               if (!ffv) begin
                  ffv   = 1'b1;
                  ffvec = s[2:0];
               end
            end
         end
         if (cov == 4'hF) begin
            dc = c;
            break;
         end
         if (c == tmo) begin
            to = 1'b1;
            dc = c;
         end
      end
      res = mk(cov, 8'(err), ffv, ffvec, 1'b1, to, (err == 0) && !to);
   endtask

   initial begin
      // Reset state
      cyc();
      chk_all("reset.d0", snap0(), mk(4'h0, 8'd0, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0));
      chk("reset.busy", 32'(if0.busy), 32'd0);
      rst = 1'b0;
      cyc();

      // Table-driven complete runs on d0
      add_vec(4'b1000, 4, 3'b000, 3'b010, 3'b100, 3'b111, 3'b000, 8'd0, 3'b000); // AND clean
      add_vec(4'b1000, 4, 3'b000, 3'b101, 3'b011, 3'b111, 3'b000, 8'd2, 3'b101); // AND, two errors
      add_vec(4'b1110, 4, 3'b000, 3'b011, 3'b101, 3'b111, 3'b000, 8'd0, 3'b000); // OR clean
      add_vec(4'b0110, 4, 3'b110, 3'b101, 3'b011, 3'b000, 3'b000, 8'd0, 3'b000); // XOR clean
      add_vec(4'b0110, 5, 3'b011, 3'b010, 3'b000, 3'b101, 3'b111, 8'd2, 3'b010); // XOR, duplicate error
      add_vec(4'b0111, 4, 3'b001, 3'b011, 3'b101, 3'b110, 3'b000, 8'd0, 3'b000); // NAND clean
      add_vec(4'b0001, 4, 3'b111, 3'b100, 3'b010, 3'b000, 3'b000, 8'd2, 3'b111); // NOR, two errors
      for (int i = 0; i < vecs.size(); i++) begin
         pulse_start(vecs[i].tt);
         chk($sformatf("vec%0d.busy", i), 32'(if0.busy), 32'd1);
         for (int j = 0; j < int'(vecs[i].n); j++) begin
            drive(1'b1, vecs[i].s[j]);
            cyc();
            if (j == int'(vecs[i].n) - 2) chk($sformatf("vec%0d.early_done", i), 32'(if0.done), 32'd0);
         end
         drive(1'b0, 3'b000);
         chk_all($sformatf("vec%0d", i), snap0(),
                 mk(vecs[i].cov, vecs[i].err, vecs[i].ffv, vecs[i].ffvec, 1'b1, 1'b0, vecs[i].pass));
         $display("vec %0d: table=%b samples=%0d err=%0d pass=%0b", i, vecs[i].tt, vecs[i].n, if0.err_count, if0.pass);
      end

      // Timeout on d0 (TIMEOUT=20) with {1,0} never sampled
      do_reset();
      pulse_start(4'b1000);
      for (int c = 1; c <= 20; c++) begin
         case (c)
            1:       drive(1'b1, 3'b000);
            2:       drive(1'b1, 3'b010);
            3:       drive(1'b1, 3'b111);
            default: drive(1'b0, 3'b000);
         endcase
         cyc();
         if (c == 19) chk("timeout.early_done", 32'(if0.done), 32'd0);
      end
      chk_all("timeout", snap0(), mk(4'b1011, 8'd0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0));
      drive(1'b1, 3'b101);
      cyc();
      cyc();
      drive(1'b0, 3'b000);
      chk_all("timeout.frozen", snap0(), mk(4'b1011, 8'd0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0));
      $display("timeout run: covered=%b timeout=%0b", if0.covered, if0.timeout);

      // Saturation on d1 (ERR_W=2)
      do_reset();
      pulse_start(4'b1000);
      for (int c = 0; c < 5; c++) begin drive(1'b1, 3'b110); cyc(); end
      drive(1'b1, 3'b000); cyc();
      drive(1'b1, 3'b010); cyc();
      drive(1'b1, 3'b100); cyc();
      drive(1'b0, 3'b000);
      chk_all("saturate", snap1(), mk(4'hF, 8'd3, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0));
      $display("saturate run: err_count=%0d first_fail=%b", if1.err_count, if1.first_fail_vec);

      // Asynchronous reset mid-run, then a clean OR run ignoring a mid-run start
      do_reset();
      pulse_start(4'b1000);
      drive(1'b1, 3'b000); cyc();
      drive(1'b1, 3'b011); cyc();
      drive(1'b0, 3'b000);
      chk("midrst.pre_err", 32'(if0.err_count), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_all("midrst", snap0(), mk(4'h0, 8'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
      chk("midrst.busy", 32'(if0.busy), 32'd0);
      cyc();
      rst = 1'b0;
      pulse_start(4'b1110);
      drive(1'b1, 3'b000); cyc();
      tt = 4'b1000; start = 1'b1;
      drive(1'b1, 3'b011); cyc();
      start = 1'b0;
      drive(1'b1, 3'b101); cyc();
      drive(1'b1, 3'b111); cyc();
      drive(1'b0, 3'b000);
      chk_all("or_after_rst", snap0(), mk(4'hF, 8'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1));
      $display("reset/restart run: pass=%0b", if0.pass);

      // d2 (TIMEOUT=4): ignore samples in IDLE, coverage beats timeout on cycle 4, restart from DONE
      do_reset();
      drive(1'b1, 3'b111); cyc();
      drive(1'b0, 3'b000);
      chk("idle_ignore.covered", 32'(if2.covered), 32'd0);
      pulse_start(4'b1000);
      drive(1'b1, 3'b000); cyc();
      drive(1'b1, 3'b010); cyc();
      drive(1'b1, 3'b100); cyc();
      chk("tie.early_done", 32'(if2.done), 32'd0);
      drive(1'b1, 3'b111); cyc();
      chk_all("tie", snap2(), mk(4'hF, 8'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1));
      drive(1'b1, 3'b110); cyc();
      drive(1'b0, 3'b000);
      chk("tie.after_ignored", 32'(if2.err_count), 32'd0);
      pulse_start(4'b0110);
      chk("restart.busy", 32'(if2.busy), 32'd1);
      chk_all("restart", snap2(), mk(4'h0, 8'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
      $display("tie/restart run: busy=%0b covered=%b", if2.busy, if2.covered);

      // Randomized runs on d0 and d1 against the reference model
      for (int r = 0; r < 30; r++) begin
         logic [3:0]  q[$];
         logic [3:0]  rt;
         logic [18:0] exp0, exp1;
         int          dc0, dc1, got0, got1, len, rot;
         rt  = 4'($urandom);
         len = $urandom_range(0, 24);
         for (int i = 0; i < len; i++) begin
            logic [1:0] k;
            logic       v, y;
            k = 2'($urandom);
            v = ($urandom % 3) != 0;
            y = (($urandom % 5) == 0) ? ~rt[k] : rt[k];
            q.push_back({v, k, y});
         end
         rot = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++) begin
            logic [1:0] k;
            logic       y;
            k = 2'((i + rot) % 4);
            y = (($urandom % 6) == 0) ? ~rt[k] : rt[k];
            q.push_back({1'b1, k, y});
         end
         model(q, rt, 20, 255, exp0, dc0);
         model(q, rt, 1000, 3, exp1, dc1);
         do_reset();
         pulse_start(rt);
         got0 = 0;
         got1 = 0;
         for (int c = 1; c <= 30; c++) begin
            if (c <= q.size()) drive(q[c-1][3], q[c-1][2:0]);
            else               drive(1'b0, 3'b000);
            cyc();
            if (if0.done && got0 == 0) got0 = c;
            if (if1.done && got1 == 0) got1 = c;
         end
         drive(1'b0, 3'b000);
         chk($sformatf("rand%0d.d0_done_cycle", r), 32'(got0), 32'(dc0));
         chk($sformatf("rand%0d.d1_done_cycle", r), 32'(got1), 32'(dc1));
         chk_all($sformatf("rand%0d.d0", r), snap0(), exp0);
         chk_all($sformatf("rand%0d.d1", r), snap1(), exp1);
         $display("rand %0d: table=%b len=%0d d0 done@%0d err=%0d to=%0b, d1 done@%0d err=%0d",
                  r, rt, q.size(), got0, if0.err_count, if0.timeout, got1, if1.err_count);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable checker for a 2-input gate under test: the receiving end of the stimulus sequence a gate bench drives.
- Samples (a, b, y) triples under a valid strobe and compares y against a programmable 4-entry truth table.
- Tracks coverage of all four input combinations and counts mismatches.
- Reports done/pass/timeout, which lets a hardware sequencer or bench self-check any basic gate (AND, OR, XOR, ...).

Parameters:
ERR_W, 8, width of the mismatch counter (saturating)
TO_W, 16, width of the RUN-cycle timeout counter
TIMEOUT, 1000, maximum RUN cycles before declaring timeout (1 <= TIMEOUT <= 2**TO_W)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins a check run
truth_table  in  4  expected y indexed by {a,b}; bit[{a,b}] (AND = 4'b1000, OR = 4'b1110)
s_valid  in  1  sample strobe
s_a  in  1  gate input a of the sample
s_b  in  1  gate input b of the sample
s_y  in  1  observed gate output of the sample
busy  out  1  high while in RUN
done  out  1  high in DONE, held until start or rst
pass  out  1  done && err_count==0 && !timeout
covered  out  4  bit[{a,b}] set once that combination has been sampled
err_count  out  ERR_W  mismatch count, saturates at all-ones
first_fail_valid  out  1  a mismatch has been captured this run
first_fail_vec  out  3  {a,b,y} of the first mismatching sample
timeout  out  1  run ended without full coverage

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; latched table 0; timer 0.
- States: IDLE, RUN, DONE.
  - IDLE: start -> latch truth_table, clear covered/err_count/first_fail/timeout/timer; RUN after that edge. busy rises the cycle after the start pulse.
  - RUN, each cycle:
    - Timer increments.
    - If s_valid: idx={s_a,s_b}; covered[idx]<=1; if s_y != table[idx], err_count increments (saturating). If first_fail_valid==0, capture first_fail_vec={s_a,s_b,s_y} and set first_fail_valid.
  - RUN exit, evaluated on the post-update value:
    - Coverage becomes 4'b1111 -> DONE, timeout=0.
    - Otherwise, if timer==TIMEOUT-1 -> DONE, timeout=1.
    - If both conditions occur on the same cycle, coverage wins and timeout=0.
  - DONE: done=1, busy=0, results frozen. start -> identical to the IDLE start behaviour (re-latch table, clear, RUN).
- Latency: done is asserted the cycle after the edge that registers the completing sample.
- start while in RUN is ignored; the table is not re-latched.
- s_valid outside RUN is ignored; no state change.
- truth_table changes during RUN have no effect; only the value latched at start is used.
- Duplicate samples of an already-covered combination are still compared and can add errors.
- Samples arriving after the completing sample, including the following cycle, are ignored.
- Saturation: err_count stays at 2**ERR_W-1, never wraps; first_fail_vec is unaffected by later mismatches.
- rst mid-RUN: immediate return to IDLE with all outputs 0; the next start begins a clean run.
- pass is combinational from registered done/err_count/timeout; it is 0 outside DONE.

Test Plan:
1. table=4'b1000; start; samples (0,0,0),(0,1,0),(1,0,0),(1,1,1) on consecutive cycles -> done=1 one cycle after the 4th sample, covered=4'b1111, err_count=0, pass=1, timeout=0.
2. table=4'b1000; samples (0,0,0),(1,0,1),(0,1,1),(1,1,1) -> err_count=2, first_fail_vec=3'b101, first_fail_valid=1, pass=0, done=1.
3. TIMEOUT=20; samples only for {0,0},{0,1},{1,1} -> done and timeout rise after RUN cycle 20, covered=4'b1011, pass=0; later samples ignored.
4. ERR_W=2; table=4'b1000; five samples (1,1,0), then the remaining combinations correct -> err_count=3 (saturated), first_fail_vec=3'b110, pass=0.
5. Mid-RUN: rst asserted between edges -> all outputs 0 without a clock edge. Then start with table=4'b1110 and a correct OR sequence -> pass=1. A start pulse mid-run with a different table is ignored.
6. TIMEOUT=4; the 4th distinct combination arrives on RUN cycle 4 -> done=1, timeout=0, covered=4'b1111. Then a start in DONE -> counters cleared, busy=1 next cycle.
